// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle MIPS-style datapath.
// Control outputs decode from the registered state and are forced low while rst is high.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       pc_en,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  state_t     r_state;
  state_t     w_next;

  logic       w_pc_write;
  logic       w_pc_write_cond;
  logic       w_iord;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_dst;
  logic       w_mem_to_reg;
  logic       w_reg_write;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic [1:0] w_pc_source;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Next-state logic; unused encodings fall back to FETCH
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = S_MEMWB;
      S_EXEC:   w_next = S_RWB;
      S_ADDIEX: w_next = S_ADDIWB;
      default:  w_next = S_FETCH;
    endcase
  end

  // Per-state control decode
  always_comb begin
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_iord          = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_reg_dst       = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_reg_write     = 1'b0;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = 2'b00;
    w_alu_op        = 2'b00;
    w_pc_source     = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_ir_write  = 1'b1;
        w_pc_write  = 1'b1;
        w_alu_src_b = 2'b01;
      end
      S_DECODE: w_alu_src_b = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
      end
      S_MEMWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
      end
      S_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b10;
      end
      S_RWB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a     = 1'b1;
        w_pc_write_cond = 1'b1;
        w_alu_op        = 2'b01;
        w_pc_source     = 2'b01;
      end
      S_JUMP: begin
        w_pc_write  = 1'b1;
        w_pc_source = 2'b10;
      end
      S_ADDIWB: w_reg_write = 1'b1;
      default: ;
    endcase
  end

  // Reset masks every strobe asynchronously so an aborted instruction leaves nothing asserted
  assign pc_write      = w_pc_write      & ~rst;
  assign pc_write_cond = w_pc_write_cond & ~rst;
  assign iord          = w_iord          & ~rst;
  assign mem_read      = w_mem_read      & ~rst;
  assign mem_write     = w_mem_write     & ~rst;
  assign ir_write      = w_ir_write      & ~rst;
  assign reg_dst       = w_reg_dst       & ~rst;
  assign mem_to_reg    = w_mem_to_reg    & ~rst;
  assign reg_write     = w_reg_write     & ~rst;
  assign alu_src_a     = w_alu_src_a     & ~rst;
  assign alu_src_b     = w_alu_src_b     & {2{~rst}};
  assign alu_op        = w_alu_op        & {2{~rst}};
  assign pc_source     = w_pc_source     & {2{~rst}};
  assign pc_en         = (w_pc_write | (w_pc_write_cond & zero)) & ~rst;
  assign state         = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle vector table with a
// scoreboard queue, plus hand-written reset-abort and strobe-count checks.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       pc_en, pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  int n_cmp  = 0;
  int n_fail = 0;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .pc_en(pc_en), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    logic       z;
    logic [3:0] exp_state;
  } vec_t;

  typedef struct {
    logic [3:0]  st;
    logic [15:0] outs;
    logic        pce;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  wire [15:0] act_outs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                          reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                          alu_op, pc_source};

  // Expected control word for a state, straight from the per-state output table
  function automatic logic [15:0] model_outs(input logic [3:0] s);
    logic [15:0] o;
    o = '0;
    case (s)
      4'd0:  begin o[15] = 1'b1; o[12] = 1'b1; o[10] = 1'b1; o[5:4] = 2'b01; end
      4'd1:  o[5:4] = 2'b11;
      4'd2, 4'd10: begin o[6] = 1'b1; o[5:4] = 2'b10; end
      4'd3:  begin o[12] = 1'b1; o[13] = 1'b1; end
      4'd4:  begin o[7] = 1'b1; o[8] = 1'b1; end
      4'd5:  begin o[11] = 1'b1; o[13] = 1'b1; end
      4'd6:  begin o[6] = 1'b1; o[3:2] = 2'b10; end
      4'd7:  begin o[7] = 1'b1; o[9] = 1'b1; end
      4'd8:  begin o[6] = 1'b1; o[14] = 1'b1; o[3:2] = 2'b01; o[1:0] = 2'b01; end
      4'd9:  begin o[15] = 1'b1; o[1:0] = 2'b10; end
      4'd11: o[7] = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_instr(input logic [5:0] op, input logic z, input int n,
                           input logic [3:0] s0, input logic [3:0] s1,
                           input logic [3:0] s2, input logic [3:0] s3,
                           input logic [3:0] s4);
    logic [3:0] seq [5];
    seq[0] = s0; seq[1] = s1; seq[2] = s2; seq[3] = s3; seq[4] = s4;
    for (int i = 0; i < n; i++) vecs.push_back('{op: op, z: z, exp_state: seq[i]});
  endtask

  task automatic step(input logic [5:0] op, input logic z, input logic [3:0] exp_st);
    exp_t e;
    opcode = op;
    zero   = z;
    e.st   = exp_st;
    e.outs = model_outs(exp_st);
    e.pce  = e.outs[15] | (e.outs[14] & z);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("state", 32'(state), 32'(e.st));
      check("outs", 32'(act_outs), 32'(e.outs));
      check("pc_en", 32'(pc_en), 32'(e.pce));
    end
  endtask

  int mw_cycles;
  int rw_cycles;
  int mw_bad_iord;

  initial begin
    rst    = 1'b1;
    opcode = 6'd0;
    zero   = 1'b0;
    mw_cycles = 0;
    rw_cycles = 0;
    mw_bad_iord = 0;

    add_instr(6'b100011, 1'b0, 5, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0);   // lw
    add_instr(6'b101011, 1'b0, 4, 4'd1, 4'd2, 4'd5, 4'd0, 4'd0);   // sw
    add_instr(6'b000100, 1'b1, 3, 4'd1, 4'd8, 4'd0, 4'd0, 4'd0);   // beq taken
    add_instr(6'b000100, 1'b0, 3, 4'd1, 4'd8, 4'd0, 4'd0, 4'd0);   // beq not taken
    add_instr(6'b111111, 1'b1, 2, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0);   // illegal
    add_instr(6'b000000, 1'b0, 4, 4'd1, 4'd6, 4'd7, 4'd0, 4'd0);   // R-type
    add_instr(6'b001000, 1'b0, 4, 4'd1, 4'd10, 4'd11, 4'd0, 4'd0); // addi
    add_instr(6'b000010, 1'b1, 3, 4'd1, 4'd9, 4'd0, 4'd0, 4'd0);   // j
    add_instr(6'b000101, 1'b0, 2, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0);   // bne is a nop here

    // Reset held: FETCH with every output low, including pc_en
    @(posedge clk);
    #2;
    zero = 1'b1;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_outs", 32'(act_outs), 32'd0);
    check("rst_pc_en", 32'(pc_en), 32'd0);

    // Release away from the edge: FETCH outputs appear in the first cycle
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_state", 32'(state), 32'd0);
    check("rel_outs", 32'(act_outs), 32'(model_outs(4'd0)));
    check("rel_pc_en", 32'(pc_en), 32'd1);
    @(posedge clk);
    #1;
    check("rel_first_edge", 32'(state), 32'd1);
    // Finish that dummy instruction as a nop before starting the table
    opcode = 6'b111111;
    @(posedge clk);
    #1;
    check("nop_back_to_fetch", 32'(state), 32'd0);

    foreach (vecs[i]) begin
      step(vecs[i].op, vecs[i].z, vecs[i].exp_state);
      if (mem_write) begin
        mw_cycles++;
        if (!iord) mw_bad_iord++;
      end
      if (reg_write) rw_cycles++;
    end
    check("mem_write_cycles", 32'(mw_cycles), 32'd1);
    check("mem_write_iord", 32'(mw_bad_iord), 32'd0);
    check("reg_write_cycles", 32'(rw_cycles), 32'd3);
    check("sb_drained", 32'(sb.size()), 32'd0);

    // Abort a lw in MEMRD with an asynchronous reset pulse
    step(6'b100011, 1'b0, 4'd1);
    step(6'b100011, 1'b0, 4'd2);
    step(6'b100011, 1'b0, 4'd3);
    check("pre_abort_mem_read", 32'(mem_read), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_state", 32'(state), 32'd0);
    check("abort_outs", 32'(act_outs), 32'd0);
    check("abort_pc_en", 32'(pc_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_rel_state", 32'(state), 32'd0);
    check("abort_rel_outs", 32'(act_outs), 32'(model_outs(4'd0)));
    step(6'b000000, 1'b0, 4'd1);
    step(6'b000000, 1'b0, 4'd6);
    check("exec_alu_op", 32'(alu_op), 32'd2);
    step(6'b000000, 1'b0, 4'd7);
    step(6'b000000, 1'b0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have no parameters.
REQ-002 clk  input  1  clock; all state changes occur on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 opcode  input  6  instruction opcode bits [31:26], taken from the instruction register output.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 pc_en  output  1  PC register write enable.
  - pc_en = pc_write | (pc_write_cond & zero).
REQ-007 pc_write, pc_write_cond  output  1 each  unconditional and branch-conditional PC write requests.
REQ-008 iord, mem_read, mem_write  output  1 each.
  - iord: memory address select, 0 = PC, 1 = ALUOut.
  - mem_read, mem_write: memory strobes.
REQ-009 ir_write  output  1  instruction register enable.
REQ-010 reg_dst, mem_to_reg, reg_write  output  1 each  register-file controls.
  - reg_dst: 1 = rd, 0 = rt.
  - mem_to_reg: 1 = MDR, 0 = ALUOut.
REQ-011 alu_src_a  output  1  ALU A select, 0 = PC, 1 = regA.
REQ-012 alu_src_b  output  2  ALU B select.
  - 00 = regB, 01 = const 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate.
REQ-013 alu_op  output  2  ALU operation: 00 = add, 01 = sub, 10 = decode funct.
REQ-014 pc_source  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-015 state  output  4  current state encoding, for debug and verification.

Function
REQ-016 SHALL implement a Moore FSM with these state encodings:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5
  - EXEC = 6, RWB = 7, BRANCH = 8, JUMP = 9, ADDIEX = 10, ADDIWB = 11
REQ-017 Transitions:
  - FETCH -> DECODE.
  - DECODE -> MEMADR for opcode 100011 (lw) or 101011 (sw).
  - DECODE -> EXEC for 000000 (R-type).
  - DECODE -> BRANCH for 000100 (beq).
  - DECODE -> ADDIEX for 001000 (addi).
  - DECODE -> JUMP for 000010 (j).
  - DECODE -> FETCH for any other opcode (treated as a nop).
REQ-018 Further transitions:
  - MEMADR -> MEMRD for lw, MEMADR -> MEMWR for sw.
  - MEMRD -> MEMWB.
  - EXEC -> RWB; ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, RWB, ADDIWB, BRANCH, JUMP -> FETCH.
REQ-019 Opcode SHALL be sampled every cycle; the instruction register holds it stable from DECODE until the next FETCH.
REQ-020 Outputs per state (any output not listed is 0):
  - FETCH: mem_read, ir_write, pc_write = 1; alu_src_b = 01.
  - DECODE: alu_src_b = 11.
  - MEMADR, ADDIEX: alu_src_a = 1; alu_src_b = 10.
  - MEMRD: mem_read = 1, iord = 1.
  - MEMWB: reg_write = 1, mem_to_reg = 1.
  - MEMWR: mem_write = 1, iord = 1.
  - EXEC: alu_src_a = 1; alu_op = 10.
  - RWB: reg_write = 1, reg_dst = 1.
  - BRANCH: alu_src_a = 1, pc_write_cond = 1; alu_op = 01; pc_source = 01.
  - JUMP: pc_write = 1; pc_source = 10.
  - ADDIWB: reg_write = 1.
REQ-021 Outputs SHALL be decoded from the registered state only, with no opcode-dependent glitches; pc_en is the only output that depends on zero.
REQ-022 Instruction latencies, measured from entering FETCH to the next FETCH:
  - lw: 5 cycles.
  - sw, R-type, addi: 4 cycles.
  - beq, j: 3 cycles.
  - illegal opcode: 2 cycles.
REQ-023 Unused encodings 12..15 SHALL go to FETCH on the next edge and drive all outputs 0.

Reset
REQ-024 While rst = 1, state SHALL be FETCH and every output, including pc_en, SHALL be 0.
REQ-025 rst asserted mid-instruction SHALL abort it immediately, with no pending write strobe held.
  - After rst deasserts, the first rising edge leaves FETCH for DECODE; FETCH outputs are active during that first cycle.

Verification
REQ-026 Reset, release, opcode = 100011 -> state sequence 0,1,2,3,4,0.
  - mem_read = 1 in states 0 and 3; reg_write = 1 only in state 4.
REQ-027 opcode = 101011 -> states 0,1,2,5,0.
  - mem_write = 1 for exactly one cycle, with iord = 1.
REQ-028 opcode = 000100 with zero = 1 -> pc_en = 1 in state 8.
  - Repeat with zero = 0 -> pc_en = 0 in state 8.
REQ-029 opcode = 111111 -> states 0,1,0, with no reg_write, mem_write, or pc_en pulse in state 1.
REQ-030 rst pulsed while in state 3 -> outputs go to 0 asynchronously, before the next clock edge.
  - After release: state = 0; next edge -> state = 1.
REQ-031 Back-to-back instructions R-type, addi, j -> states 0,1,6,7,0,1,10,11,0,1,9,0.
  - alu_op = 10 only in state 6; pc_source = 10 only in state 9.
